prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 16 +
 rtl/word_packer.sv | 45 ++++
 rtl/prog_loader.sv | 120 ++++++++++++
 tb/tb_prog_loader.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
// The loader FSM and the word packer both import this package.
package loader_pkg;

  localparam int unsigned DefaultMaxWords = 256;

  typedef enum logic [2:0] {
    StLenLo,
    StLenHi,
    StData,
    StCheck,
    StDone,
    StErr
  } loader_state_e;

endpackage

// File: rtl/word_packer.sv
// Packs accepted bytes little-endian into 32-bit words.
// word_ready pulses once per complete word; word holds its value until the next word completes.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_ready,
  output logic [31:0] word
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;
  logic [31:0] word_q;
  logic        ready_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
      word_q  <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (byte_valid) begin
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          word_q  <= {byte_data, shift_q};
          ready_q <= 1'b1;
        end else begin
          // Earlier bytes drift toward bit 0, so the first byte ends up in bits 7:0.
          shift_q <= {byte_data, shift_q[23:8]};
        end
      end
    end
  end

  assign last_byte  = (cnt_q == 2'd3);
  assign word_ready = ready_q;
  assign word       = word_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction memory
// and releases the downstream core only after the checksum matches.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = DefaultMaxWords,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  loader_state_e state_q, state_d;
  logic          ready_q, ready_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [31:0]   addr_q, addr_d;

  logic          accept;
  logic          data_byte;
  logic          last_byte;
  logic          word_ready;
  logic [31:0]   word;
  logic [15:0]   n_rx;

  assign accept    = rx_valid & ready_q;
  assign data_byte = accept & (state_q == StData);
  assign n_rx      = {rx_data, len_lo_q};

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .last_byte  (last_byte),
    .word_ready (word_ready),
    .word       (word)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    n_d      = n_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    addr_d   = addr_q;
    unique case (state_q)
      StLenLo: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          n_d = n_rx;
          if (n_rx == 16'd0 || 32'(n_rx) > MAX_WORDS) state_d = StErr;
          else                                         state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ rx_data;
          if (last_byte) begin
            // Address is latched alongside the packed word so both hold after the strobe.
            addr_d = BASE_ADDR + 32'({idx_q, 2'b00});
            idx_d  = idx_q + 16'd1;
            if (idx_q == n_q - 16'd1) state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (accept) state_d = (rx_data == csum_q) ? StDone : StErr;
      end
      default: ;
    endcase
    ready_d = (state_d == StLenLo) || (state_d == StLenHi) ||
              (state_d == StData)  || (state_d == StCheck);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StLenLo;
      ready_q  <= 1'b0;
      len_lo_q <= 8'd0;
      n_q      <= 16'd0;
      idx_q    <= 16'd0;
      csum_q   <= 8'd0;
      addr_q   <= BASE_ADDR;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      len_lo_q <= len_lo_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      addr_q   <= addr_d;
    end
  end

  assign rx_ready   = ready_q;
  assign imem_we    = word_ready;
  assign imem_addr  = addr_q;
  assign imem_wdata = word;
  assign cpu_hold   = (state_q != StDone);
  assign done       = (state_q == StDone);
  assign err        = (state_q == StErr);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (default params, and a small MAX_WORDS at base 0x100)
// share one byte stream; a stream-level model predicts writes, timing and final outcome.
module tb_prog_loader;

  localparam int unsigned MaxA  = 256;
  localparam int unsigned MaxB  = 8;
  localparam logic [31:0] BaseA = 32'h0000_0000;
  localparam logic [31:0] BaseB = 32'h0000_0100;

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        ready_w [2];
  logic        we_w    [2];
  logic [31:0] addr_w  [2];
  logic [31:0] wdata_w [2];
  logic        hold_w  [2];
  logic        done_w  [2];
  logic        err_w   [2];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  logic [7:0]  stream_q [$];
  int          scyc_q   [$];
  logic [7:0]  cs_acc;
  wr_t         obs_q    [$];
  int          term_cyc [2];
  int          hold_bad [2];
  logic [31:0] last_addr[2];
  logic [31:0] last_data[2];

  wr_t         m_wr [$];
  int          m_out;   // 0 still loading, 1 done, 2 err
  int          m_term;

  prog_loader #(.MAX_WORDS(MaxA), .BASE_ADDR(BaseA)) u_dut_a (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(ready_w[0]),
    .imem_we(we_w[0]), .imem_addr(addr_w[0]), .imem_wdata(wdata_w[0]),
    .cpu_hold(hold_w[0]), .done(done_w[0]), .err(err_w[0])
  );

  prog_loader #(.MAX_WORDS(MaxB), .BASE_ADDR(BaseB)) u_dut_b (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(ready_w[1]),
    .imem_we(we_w[1]), .imem_addr(addr_w[1]), .imem_wdata(wdata_w[1]),
    .cpu_hold(hold_w[1]), .done(done_w[1]), .err(err_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe write strobes, first terminal cycle and address/data stability between writes.
  always @(negedge clk) begin
    wr_t w;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        last_addr[d] = (d == 0) ? BaseA : BaseB;
        last_data[d] = 32'd0;
      end else begin
        if (we_w[d]) begin
          w.d = d; w.addr = addr_w[d]; w.data = wdata_w[d]; w.cyc = cyc;
          obs_q.push_back(w);
          last_addr[d] = addr_w[d];
          last_data[d] = wdata_w[d];
        end else if (addr_w[d] !== last_addr[d] || wdata_w[d] !== last_data[d]) begin
          hold_bad[d]++;
        end
        if ((done_w[d] || err_w[d]) && term_cyc[d] < 0) term_cyc[d] = cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    rx_valid = 1'b0;
    step(2);
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst/d%0d/ready", d), 64'(ready_w[d]), 64'(0));
      check_eq($sformatf("rst/d%0d/we", d),    64'(we_w[d]),    64'(0));
      check_eq($sformatf("rst/d%0d/addr", d),  64'(addr_w[d]),  64'((d == 0) ? BaseA : BaseB));
      check_eq($sformatf("rst/d%0d/wdata", d), 64'(wdata_w[d]), 64'(0));
      check_eq($sformatf("rst/d%0d/hold", d),  64'(hold_w[d]),  64'(1));
      check_eq($sformatf("rst/d%0d/done", d),  64'(done_w[d]),  64'(0));
      check_eq($sformatf("rst/d%0d/err", d),   64'(err_w[d]),   64'(0));
      term_cyc[d] = -1;
      hold_bad[d] = 0;
    end
    obs_q.delete();
    stream_q.delete();
    scyc_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rel/ready_lo", 64'({ready_w[0], ready_w[1]}), 64'(0));
    @(posedge clk);
    #1;
    check_eq("rel/ready_hi", 64'({ready_w[0], ready_w[1]}), 64'(3));
  endtask

  task automatic img_begin(input int n);
    stream_q.push_back(8'(n));
    stream_q.push_back(8'(n >> 8));
    cs_acc = 8'd0;
  endtask

  task automatic pay(input logic [7:0] b);
    stream_q.push_back(b);
    cs_acc ^= b;
  endtask

  task automatic img_end(input logic [7:0] mask);
    stream_q.push_back(cs_acc ^ mask);
  endtask

  // gap: 0 back-to-back, 1 idle cycle before every byte, 2 random idle cycles.
  task automatic send(input int gap);
    for (int i = 0; i < stream_q.size(); i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        rx_data = 8'($urandom);
        step(1);
      end
      rx_valid = 1'b1;
      rx_data  = stream_q[i];
      scyc_q.push_back(cyc);
      step(1);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
  endtask

  // Predicts the loader's behaviour directly from the stream format.
  task automatic run_model(input int maxw, input logic [31:0] base);
    int          n;
    int          b;
    logic [7:0]  cs;
    wr_t         w;
    m_wr.delete();
    m_out  = 0;
    m_term = -1;
    if (stream_q.size() < 2) return;
    n = int'(stream_q[1]) * 256 + int'(stream_q[0]);
    if (n == 0 || n > maxw) begin
      m_out  = 2;
      m_term = scyc_q[1] + 1;
      return;
    end
    cs = 8'd0;
    for (int k = 0; k < n; k++) begin
      b = 2 + 4 * k;
      if (stream_q.size() < b + 4) return;
      w.d    = 0;
      w.addr = base + 32'(4 * k);
      w.data = {stream_q[b + 3], stream_q[b + 2], stream_q[b + 1], stream_q[b]};
      w.cyc  = scyc_q[b + 3] + 1;
      m_wr.push_back(w);
      cs ^= stream_q[b] ^ stream_q[b + 1] ^ stream_q[b + 2] ^ stream_q[b + 3];
    end
    if (stream_q.size() < 3 + 4 * n) return;
    m_out  = (stream_q[2 + 4 * n] == cs) ? 1 : 2;
    m_term = scyc_q[2 + 4 * n] + 1;
  endtask

  task automatic compare(input int d, input int maxw, input logic [31:0] base, input string name);
    wr_t got [$];
    string t;
    run_model(maxw, base);
    foreach (obs_q[i]) if (obs_q[i].d == d) got.push_back(obs_q[i]);
    t = $sformatf("%s/d%0d", name, d);
    check_eq({t, "/nwr"}, 64'(got.size()), 64'(m_wr.size()));
    for (int i = 0; i < m_wr.size() && i < got.size(); i++) begin
      check_eq($sformatf("%s/addr%0d", t, i), 64'(got[i].addr), 64'(m_wr[i].addr));
      check_eq($sformatf("%s/data%0d", t, i), 64'(got[i].data), 64'(m_wr[i].data));
      check_eq($sformatf("%s/wcyc%0d", t, i), 64'(got[i].cyc),  64'(m_wr[i].cyc));
    end
    check_eq({t, "/done"},  64'(done_w[d]),  64'(m_out == 1));
    check_eq({t, "/err"},   64'(err_w[d]),   64'(m_out == 2));
    check_eq({t, "/hold"},  64'(hold_w[d]),  64'(m_out != 1));
    check_eq({t, "/ready"}, 64'(ready_w[d]), 64'(m_out == 0));
    check_eq({t, "/tcyc"},  64'(term_cyc[d]), 64'(m_term));
    check_eq({t, "/stable"}, 64'(hold_bad[d]), 64'(0));
  endtask

  task automatic finish_test(input string name);
    step(3);
    compare(0, MaxA, BaseA, name);
    compare(1, MaxB, BaseB, name);
  endtask

  initial begin
    int n;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;

    // Single word, good checksum.
    do_reset();
    img_begin(1); pay(8'h13); pay(8'h00); pay(8'h00); pay(8'h00); img_end(8'h00);
    send(0);
    finish_test("n1");

    // Two words with rx_valid gapped every other cycle.
    do_reset();
    img_begin(2);
    pay(8'h93); pay(8'h00); pay(8'h50); pay(8'h00);
    pay(8'h13); pay(8'h01); pay(8'h10); pay(8'h00);
    img_end(8'h00);
    send(1);
    finish_test("n2gap");

    // Bad checksum: write still lands, then error.
    do_reset();
    img_begin(1); pay(8'h13); pay(8'h00); pay(8'h00); pay(8'h00); img_end(8'h13);
    send(0);
    finish_test("badcs");

    // Zero-length header followed by stray bytes.
    do_reset();
    img_begin(0); pay(8'h13); pay(8'h00); pay(8'h00); pay(8'h00); img_end(8'h00);
    send(0);
    finish_test("n0");

    // Length MAX_WORDS+1 of the default instance.
    do_reset();
    img_begin(MaxA + 1);
    for (int i = 0; i < 8; i++) pay(8'($urandom));
    img_end(8'h00);
    send(2);
    finish_test("ntoobig");

    // Reset after the second payload byte, then a fresh image.
    do_reset();
    img_begin(1); pay(8'hAA); pay(8'hBB);
    send(0);
    step(2);
    check_eq("abort/nowr", 64'(obs_q.size()), 64'(0));
    check_eq("abort/ready", 64'({ready_w[0], ready_w[1]}), 64'(3));
    do_reset();
    img_begin(1); pay(8'h13); pay(8'h00); pay(8'h00); pay(8'h00); img_end(8'h00);
    send(0);
    finish_test("abort");

    // Exactly MAX_WORDS for the small instance, one over, and the full default maximum.
    do_reset();
    img_begin(MaxB);
    for (int i = 0; i < 4 * MaxB; i++) pay(8'($urandom));
    img_end(8'h00);
    send(2);
    finish_test("nmaxb");

    do_reset();
    img_begin(MaxB + 1);
    for (int i = 0; i < 4 * (MaxB + 1); i++) pay(8'($urandom));
    img_end(8'h00);
    send(0);
    finish_test("nmaxb1");

    do_reset();
    img_begin(MaxA);
    for (int i = 0; i < 4 * MaxA; i++) pay(8'($urandom));
    img_end(8'h00);
    send(0);
    finish_test("nmaxa");

    // Random images, occasionally corrupted.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      n = $urandom_range(1, 12);
      img_begin(n);
      for (int i = 0; i < 4 * n; i++) pay(8'($urandom));
      img_end(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      send(2);
      finish_test($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
